// File: rtl/vga_fb_pkg.sv
// Shared constants, scheduler state type and framebuffer address helper
// for the VGA framebuffer port scheduler.
package vga_fb_pkg;

    localparam int FB_W   = 320;
    localparam int FB_H   = 240;
    localparam int H_VIS  = 640;
    localparam int V_VIS  = 480;
    localparam int PIX_W  = 12;
    localparam int ADDR_W = 17;

    typedef enum logic [1:0] {
        DISABLED,
        ARMED,
        ACTIVE,
        DRAIN
    } sched_state_t;

    // (y>>1)*320 + (x>>1) as shift-add: 320 = 256 + 64.
    function automatic logic [ADDR_W-1:0] fb_addr(
        input logic [9:0] x,
        input logic [9:0] y
    );
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        row = ADDR_W'(y >> 1);
        col = ADDR_W'(x >> 1);
        return (row << 8) + (row << 6) + col;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// N-stage delay for {DE, h_sync, v_sync} so they line up with the pixel.
// Ports: clk, reset, de/h_sync/v_sync in, de_d/h_sync_d/v_sync_d out.
module vga_sync_delay #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic de,
    input  logic h_sync,
    input  logic v_sync,
    output logic de_d,
    output logic h_sync_d,
    output logic v_sync_d
);

    logic [N-1:0] de_sr;
    logic [N-1:0] hs_sr;
    logic [N-1:0] vs_sr;

    // Syncs are active-low, so their idle/reset level is 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_sr <= '0;
            hs_sr <= '1;
            vs_sr <= '1;
        end else begin
            de_sr[0] <= de;
            hs_sr[0] <= h_sync;
            vs_sr[0] <= v_sync;
            for (int i = 1; i < N; i++) begin
                de_sr[i] <= de_sr[i-1];
                hs_sr[i] <= hs_sr[i-1];
                vs_sr[i] <= vs_sr[i-1];
            end
        end
    end

    assign de_d     = de_sr[N-1];
    assign h_sync_d = hs_sr[N-1];
    assign v_sync_d = vs_sr[N-1];

endmodule

// File: rtl/vga_fb_port_scheduler.sv
// Shares one single-port framebuffer RAM between 2x2-doubled VGA scan-out
// and a writer. Ports: raster in (x/y/DE/syncs), enable, writer valid/ready,
// RAM en/we/addr/wdata/rdata, delayed syncs, rgb and frame_active out.
module vga_fb_port_scheduler
    import vga_fb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        x_pixel,
    input  logic [9:0]        y_pixel,
    input  logic              DE,
    input  logic              h_sync,
    input  logic              v_sync,
    input  logic              enable,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_de,
    output logic [PIX_W-1:0]  rgb,
    output logic              frame_active
);

    sched_state_t      state;
    sched_state_t      state_nx;
    logic              frame_start;
    logic              scan_on;
    logic              rd_slot;
    logic              rd_d1;
    logic              act_d1;
    logic              act_d2;
    logic [PIX_W-1:0]  pix_q;

    assign frame_start = (x_pixel == 10'd0) && (y_pixel == 10'd0);

    always_comb begin
        state_nx = state;
        unique case (state)
            DISABLED: if (enable) state_nx = ARMED;
            ARMED: begin
                if (!enable)          state_nx = DISABLED;
                else if (frame_start) state_nx = ACTIVE;
            end
            ACTIVE:   if (!enable)     state_nx = DRAIN;
            DRAIN:    if (frame_start) state_nx = DISABLED;
            default:  state_nx = DISABLED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= DISABLED;
            frame_active <= 1'b0;
        end else begin
            state        <= state_nx;
            frame_active <= (state_nx == ACTIVE) || (state_nx == DRAIN);
        end
    end

    // frame_active is registered, so on the frame-start pixel itself the
    // scan-out decision follows the state being entered: the pixel at
    // (0,0) belongs to the new frame, not to the one that just ended.
    assign scan_on = frame_start
                   ? ((state_nx == ACTIVE) || (state_nx == DRAIN))
                   : frame_active;

    assign rd_slot  = scan_on && DE && !x_pixel[0];
    assign wr_ready = !rd_slot;

    always_comb begin
        mem_wdata = wr_data;
        if (rd_slot) begin
            mem_en   = 1'b1;
            mem_we   = 1'b0;
            mem_addr = fb_addr(x_pixel, y_pixel);
        end else begin
            mem_en   = wr_valid;
            mem_we   = wr_valid;
            mem_addr = wr_addr;
        end
    end

    // Read data arrives one cycle after the read slot; the pixel register
    // then holds for the two raster columns that share the fb pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_d1  <= 1'b0;
            act_d1 <= 1'b0;
            act_d2 <= 1'b0;
            pix_q  <= '0;
        end else begin
            rd_d1  <= rd_slot;
            act_d1 <= scan_on;
            act_d2 <= act_d1;
            if (rd_d1) pix_q <= mem_rdata;
        end
    end

    vga_sync_delay #(
        .N(2)
    ) u_sync_delay (
        .clk      (clk),
        .reset    (reset),
        .de       (DE),
        .h_sync   (h_sync),
        .v_sync   (v_sync),
        .de_d     (vga_de),
        .h_sync_d (vga_hsync),
        .v_sync_d (vga_vsync)
    );

    assign rgb = (vga_de && act_d2) ? pix_q : '0;

endmodule
